// File: rtl/out_pkg.sv
// Shared constants, state encodings and the round-robin helper for the
// output-port UART reporter.
package out_pkg;

  localparam int         NUM_PORTS = 16;
  localparam logic [3:0] FRAME_HDR = 4'hA;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_BYTE0,
    FR_BYTE1
  } frame_state_e;

  // Search starts one past the previous winner, so the previous winner is checked last.
  function automatic logic [3:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                         input logic [3:0]           last);
    logic [3:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = last + 4'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start pulse during the last STOP cycle chains the
// next byte directly, with no idle gap between bytes.
module uart_tx_byte
  import out_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;
  logic             load;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign load    = start && ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      if ((state == TX_IDLE) || bit_end) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;

      if (state == TX_START)                 bit_idx <= 3'd0;
      else if ((state == TX_DATA) && bit_end) bit_idx <= bit_idx + 3'd1;

      if (load) shreg <= data_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (start) state_next = TX_START;
      TX_START: if (bit_end) state_next = TX_DATA;
      TX_DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = TX_STOP;
      TX_STOP:  if (bit_end) state_next = start ? TX_START : TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != TX_IDLE);
    done = (state == TX_STOP) && bit_end;
    case (state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shreg[bit_idx];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/out_uart_tx.sv
// Watches the 16 output-port registers and reports every change as a
// {header, data} frame on a single UART line, serving ports round-robin.
module out_uart_tx
  import out_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] out_00,
  input  logic [7:0] out_01,
  input  logic [7:0] out_02,
  input  logic [7:0] out_03,
  input  logic [7:0] out_04,
  input  logic [7:0] out_05,
  input  logic [7:0] out_06,
  input  logic [7:0] out_07,
  input  logic [7:0] out_08,
  input  logic [7:0] out_09,
  input  logic [7:0] out_10,
  input  logic [7:0] out_11,
  input  logic [7:0] out_12,
  input  logic [7:0] out_13,
  input  logic [7:0] out_14,
  input  logic [7:0] out_15,
  output logic       tx,
  output logic       busy
);

  logic [7:0]           port_val [NUM_PORTS];
  logic [7:0]           shadow   [NUM_PORTS];
  logic [NUM_PORTS-1:0] dirty;
  logic [3:0]           last_sel;
  logic [3:0]           winner;
  logic [7:0]           data_q;
  frame_state_e         frame_state, frame_next;
  logic                 capture;
  logic                 byte_start;
  logic                 byte_done;
  logic [7:0]           byte_data;

  assign port_val[0]  = out_00;
  assign port_val[1]  = out_01;
  assign port_val[2]  = out_02;
  assign port_val[3]  = out_03;
  assign port_val[4]  = out_04;
  assign port_val[5]  = out_05;
  assign port_val[6]  = out_06;
  assign port_val[7]  = out_07;
  assign port_val[8]  = out_08;
  assign port_val[9]  = out_09;
  assign port_val[10] = out_10;
  assign port_val[11] = out_11;
  assign port_val[12] = out_12;
  assign port_val[13] = out_13;
  assign port_val[14] = out_14;
  assign port_val[15] = out_15;

  always_comb begin
    dirty = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dirty[i] = (port_val[i] != shadow[i]);
    end
  end

  assign winner  = rr_pick(dirty, last_sel);
  assign capture = (frame_state == FR_IDLE) && enable && (|dirty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_state <= FR_IDLE;
    else       frame_state <= frame_next;
  end

  // Shadow takes the captured value, so a port that changes mid-frame stays dirty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        shadow[i] <= 8'h00;
      end
      last_sel <= 4'd15;
      data_q   <= 8'h00;
    end else if (capture) begin
      shadow[winner] <= port_val[winner];
      data_q         <= port_val[winner];
      last_sel       <= winner;
    end
  end

  always_comb begin
    frame_next = frame_state;
    case (frame_state)
      FR_IDLE:  if (capture) frame_next = FR_BYTE0;
      FR_BYTE0: if (byte_done) frame_next = FR_BYTE1;
      FR_BYTE1: if (byte_done) frame_next = FR_IDLE;
      default:  frame_next = FR_IDLE;
    endcase
  end

  always_comb begin
    byte_start = capture || ((frame_state == FR_BYTE0) && byte_done);
    byte_data  = (frame_state == FR_IDLE) ? {FRAME_HDR, winner} : data_q;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .reset  (reset),
    .start  (byte_start),
    .data_in(byte_data),
    .tx     (tx),
    .busy   (busy),
    .done   (byte_done)
  );

endmodule
